// File: rtl/if_stage.sv
// Instruction fetch: assembles 32-bit words from an 8-bit memory port (LE), ISSUE holds on stall_in.
// Miss: ins_valid 4 cycles after FETCH entry at full byte rate; optional ICACHE_EN cache hit: 1 cycle.
// Backpressure: stall_in freezes the issued word; rdy_in low freezes all state; jump_flag redirects.
module if_stage #(
    parameter int ICACHE_LINES = 128
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        if_mem_req,
    output logic [31:0] if_mem_addr,
    input  logic        mem_if_valid,
    input  logic [7:0]  mem_if_data,
    input  logic        jump_flag,
    input  logic [31:0] jump_target,
    input  logic        stall_in,
    output logic [31:0] pc,
    output logic [31:0] ins,
    output logic        ins_valid
);

    typedef enum logic {FETCH = 1'b0, ISSUE = 1'b1} state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [23:0] buf_q, buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ins_q, ins_d;
    logic        ins_valid_q, ins_valid_d;

    logic        cache_hit;
    logic [31:0] cache_word;
    logic        take_byte;
    logic        word_done;

    assign take_byte = rdy_in && !jump_flag && (state_q == FETCH) && !cache_hit && mem_if_valid;
    assign word_done = take_byte && (byte_cnt_q == 2'd3);

`ifdef ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [31:0]             cache_dat_q [ICACHE_LINES];
    logic [TAG_W-1:0]        cache_tag_q [ICACHE_LINES];
    logic [ICACHE_LINES-1:0] cache_vld_q, cache_vld_d;
    logic [IDX_W-1:0]        rd_idx;
    logic [TAG_W-1:0]        rd_tag;

    assign rd_idx     = fetch_pc_q[IDX_W+1:2];
    assign rd_tag     = fetch_pc_q[31:IDX_W+2];
    assign cache_word = cache_dat_q[rd_idx];
    // Lookup only at the start of a word so a partially fetched word never hits mid-way.
    assign cache_hit  = (state_q == FETCH) && (byte_cnt_q == 2'd0) &&
                        cache_vld_q[rd_idx] && (cache_tag_q[rd_idx] == rd_tag);

    always_comb begin
        cache_vld_d = cache_vld_q;
        if (word_done) begin
            cache_vld_d[rd_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (word_done) begin
            cache_dat_q[rd_idx] <= {mem_if_data, buf_q};
            cache_tag_q[rd_idx] <= rd_tag;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cache_vld_q <= '0;
        end else begin
            cache_vld_q <= cache_vld_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (ICACHE_LINES != 0);
    assign cache_hit  = 1'b0;
    assign cache_word = 32'd0;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (rdy_in) begin
            if (jump_flag) begin
                state_d = FETCH;
            end else begin
                case (state_q)
                    FETCH:   if (cache_hit || word_done) state_d = ISSUE;
                    ISSUE:   if (!stall_in) state_d = FETCH;
                    default: state_d = FETCH;
                endcase
            end
        end
    end

    always_comb begin
        if_mem_req  = 1'b0;
        if_mem_addr = 32'd0;
        if (!rst_in) begin
            if_mem_addr = fetch_pc_q + {30'd0, byte_cnt_q};
            if_mem_req  = (state_q == FETCH) && !cache_hit && !(rdy_in && jump_flag);
        end
    end

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        pc_d        = pc_q;
        ins_d       = ins_q;
        ins_valid_d = ins_valid_q;
        if (rdy_in) begin
            if (jump_flag) begin
                fetch_pc_d  = jump_target;
                byte_cnt_d  = 2'd0;
                ins_valid_d = 1'b0;
            end else if (state_q == FETCH) begin
                if (cache_hit) begin
                    ins_d       = cache_word;
                    pc_d        = fetch_pc_q;
                    ins_valid_d = 1'b1;
                end else if (take_byte) begin
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    case (byte_cnt_q)
                        2'd0: buf_d[7:0]   = mem_if_data;
                        2'd1: buf_d[15:8]  = mem_if_data;
                        2'd2: buf_d[23:16] = mem_if_data;
                        default: begin
                            ins_d       = {mem_if_data, buf_q};
                            pc_d        = fetch_pc_q;
                            ins_valid_d = 1'b1;
                        end
                    endcase
                end
            end else if (!stall_in) begin
                ins_valid_d = 1'b0;
                fetch_pc_d  = fetch_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            fetch_pc_q  <= 32'd0;
            byte_cnt_q  <= 2'd0;
            buf_q       <= 24'd0;
            pc_q        <= 32'd0;
            ins_q       <= 32'd0;
            ins_valid_q <= 1'b0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            pc_q        <= pc_d;
            ins_q       <= ins_d;
            ins_valid_q <= ins_valid_d;
        end
    end

    assign pc        = pc_q;
    assign ins       = ins_q;
    assign ins_valid = ins_valid_q;

endmodule
